// File: rtl/chacha_pkg.sv
// Shared widths, FSM state type and counter-range helper for the ChaCha stream controller.
package chacha_pkg;

    localparam int CHACHA_BLK_W = 512;
    localparam int CHACHA_KEY_W = 256;
    localparam int CHACHA_CTR_W = 64;
    localparam int CHACHA_IV_W  = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IN,
        ST_ISSUE,
        ST_RUN,
        ST_FLUSH
    } chacha_ctrl_state_t;

    // High when the last counter a job uses lies beyond 2^64-1. An empty job
    // consumes no counter values, so it can never wrap.
    function automatic logic ctr_range_wraps(
        input logic [CHACHA_CTR_W-1:0] start_ctr,
        input logic [CHACHA_CTR_W-1:0] nblk
    );
        logic [CHACHA_CTR_W:0] last_ctr;
        last_ctr = {1'b0, start_ctr} + {1'b0, nblk} - (CHACHA_CTR_W+1)'(1);
        return (nblk != '0) && last_ctr[CHACHA_CTR_W];
    endfunction

endpackage

// File: rtl/chacha_out_buf.sv
// One-entry valid/ready output register carrying {last, data}; load wins over drain,
// clear drops any pending entry.
module chacha_out_buf
    import chacha_pkg::*;
#(
    parameter int W = CHACHA_BLK_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic         load_last,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic         out_last,
    output logic [W-1:0] out_data,
    output logic         empty,
    output logic         drain
);

    assign empty = !out_valid;
    assign drain = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            // NOTE: the data register is reset only so the bus reads zero after reset;
            // the valid flag alone decides whether its contents mean anything.
            out_data  <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_last  <= load_last;
            out_data  <= load_data;
        end else if (drain) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/chacha_stream_ctrl.sv
// Sequences a job (key, IV, start counter, block count) through one chacha_core:
// init for the first block, next for the rest, results through a one-entry output buffer.
module chacha_stream_ctrl
    import chacha_pkg::*;
#(
    parameter int NBLK_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [CHACHA_KEY_W-1:0] job_key,
    input  logic [CHACHA_IV_W-1:0]  job_iv,
    input  logic [CHACHA_CTR_W-1:0] job_ctr,
    input  logic [NBLK_W-1:0]       job_nblk,
    input  logic                    abort,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CHACHA_BLK_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CHACHA_BLK_W-1:0] out_data,
    output logic                    out_last,
    output logic                    core_init,
    output logic                    core_next,
    output logic [CHACHA_KEY_W-1:0] core_key,
    output logic [CHACHA_IV_W-1:0]  core_iv,
    output logic [CHACHA_CTR_W-1:0] core_ctr,
    output logic [CHACHA_BLK_W-1:0] core_data_in,
    input  logic                    core_ready,
    input  logic                    core_data_out_valid,
    input  logic [CHACHA_BLK_W-1:0] core_data_out,
    output logic                    busy,
    output logic                    done,
    output logic [NBLK_W-1:0]       blk_idx,
    output logic                    ctr_wrap
);

    chacha_ctrl_state_t state, state_nxt;

    logic [NBLK_W-1:0] nblk_q;
    logic              done_q;
    logic              flush_done;
    logic              abort_act;
    logic              job_hs;
    logic              in_hs;
    logic              buf_load;
    logic              buf_empty;
    logic              buf_drain;
    logic              buf_free;

    assign abort_act = abort && (state != ST_IDLE);
    assign job_hs    = job_valid && job_ready;
    assign in_hs     = in_valid && in_ready;
    // A result may only be issued when its output slot is guaranteed free on arrival.
    assign buf_free  = buf_empty || buf_drain;
    assign busy      = !rst && (state != ST_IDLE);
    assign done      = done_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through
        // the case leaves one unassigned and no latch is inferred.
        state_nxt  = state;
        job_ready  = 1'b0;
        in_ready   = 1'b0;
        core_init  = 1'b0;
        core_next  = 1'b0;
        buf_load   = 1'b0;
        flush_done = 1'b0;

        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    // core_ready keeps a result still in flight from an aborted job out of the next one.
                    job_ready = core_ready && !done_q;
                    if (job_valid && job_ready)
                        state_nxt = (job_nblk == '0) ? ST_FLUSH : ST_WAIT_IN;
                end
                ST_WAIT_IN: begin
                    in_ready = 1'b1;
                    if (in_valid)
                        state_nxt = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (core_ready && buf_free) begin
                        core_init = (blk_idx == '0);
                        core_next = (blk_idx != '0);
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (core_data_out_valid) begin
                        buf_load  = 1'b1;
                        state_nxt = (blk_idx < nblk_q) ? ST_WAIT_IN : ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (buf_free) begin
                        flush_done = 1'b1;
                        state_nxt  = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase

            if (abort_act) begin
                state_nxt  = ST_IDLE;
                in_ready   = 1'b0;
                core_init  = 1'b0;
                core_next  = 1'b0;
                buf_load   = 1'b0;
                flush_done = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            nblk_q       <= '0;
            blk_idx      <= '0;
            ctr_wrap     <= 1'b0;
            done_q       <= 1'b0;
            core_key     <= '0;
            core_iv      <= '0;
            core_ctr     <= '0;
            core_data_in <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here updates from the
            // values of the previous cycle, independent of statement order.
            state  <= state_nxt;
            done_q <= flush_done;
            if (job_hs) begin
                core_key <= job_key;
                core_iv  <= job_iv;
                core_ctr <= job_ctr;
                nblk_q   <= job_nblk;
                blk_idx  <= '0;
                ctr_wrap <= ctr_range_wraps(job_ctr, CHACHA_CTR_W'(job_nblk));
            end
            if (in_hs)
                core_data_in <= in_data;
            if (core_init || core_next)
                blk_idx <= blk_idx + NBLK_W'(1);
        end
    end

    chacha_out_buf #(
        .W(CHACHA_BLK_W)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (abort_act),
        .load      (buf_load),
        .load_last (blk_idx == nblk_q),
        .load_data (core_data_out),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .empty     (buf_empty),
        .drain     (buf_drain)
    );

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Bench for chacha_stream_ctrl: job table plus abort/reset sequences, a behavioural core
// with fixed latency, and an output scoreboard fed at each input-block handshake.
module tb_chacha_stream_ctrl;
    import chacha_pkg::*;

    localparam int NBLK_W   = 16;
    localparam int CORE_LAT = 4;
    localparam int TMO      = 2000;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    job_valid;
    logic                    job_ready;
    logic [CHACHA_KEY_W-1:0] job_key;
    logic [CHACHA_IV_W-1:0]  job_iv;
    logic [CHACHA_CTR_W-1:0] job_ctr;
    logic [NBLK_W-1:0]       job_nblk;
    logic                    abort;
    logic                    in_valid;
    logic                    in_ready;
    logic [CHACHA_BLK_W-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [CHACHA_BLK_W-1:0] out_data;
    logic                    out_last;
    logic                    core_init;
    logic                    core_next;
    logic [CHACHA_KEY_W-1:0] core_key;
    logic [CHACHA_IV_W-1:0]  core_iv;
    logic [CHACHA_CTR_W-1:0] core_ctr;
    logic [CHACHA_BLK_W-1:0] core_data_in;
    logic                    core_ready;
    logic                    core_data_out_valid;
    logic [CHACHA_BLK_W-1:0] core_data_out;
    logic                    busy;
    logic                    done;
    logic [NBLK_W-1:0]       blk_idx;
    logic                    ctr_wrap;

    always #5 clk = ~clk;

    chacha_stream_ctrl #(.NBLK_W(NBLK_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .job_valid           (job_valid),
        .job_ready           (job_ready),
        .job_key             (job_key),
        .job_iv              (job_iv),
        .job_ctr             (job_ctr),
        .job_nblk            (job_nblk),
        .abort               (abort),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_last            (out_last),
        .core_init           (core_init),
        .core_next           (core_next),
        .core_key            (core_key),
        .core_iv             (core_iv),
        .core_ctr            (core_ctr),
        .core_data_in        (core_data_in),
        .core_ready          (core_ready),
        .core_data_out_valid (core_data_out_valid),
        .core_data_out       (core_data_out),
        .busy                (busy),
        .done                (done),
        .blk_idx             (blk_idx),
        .ctr_wrap            (ctr_wrap)
    );

    typedef struct {
        logic [CHACHA_KEY_W-1:0] key;
        logic [CHACHA_IV_W-1:0]  iv;
        logic [CHACHA_CTR_W-1:0] ctr;
        int                      nblk;
        int                      stall;
        bit                      exp_wrap;
    } job_vec_t;

    typedef struct {
        logic [CHACHA_BLK_W-1:0] data;
        logic [CHACHA_KEY_W-1:0] key;
        logic [CHACHA_IV_W-1:0]  iv;
        logic [CHACHA_CTR_W-1:0] ctr;
        bit                      last;
    } feed_t;

    typedef struct {
        logic [CHACHA_BLK_W-1:0] data;
        bit                      last;
    } exp_t;

    feed_t feed_q[$];
    exp_t  exp_q[$];

    int n_pass = 0;
    int n_checks = 0;
    int cyc = 0;
    int n_init = 0;
    int n_next = 0;
    int n_done = 0;
    int n_both = 0;
    int n_outv = 0;
    int n_out = 0;
    int n_hold_viol = 0;
    int init_cyc = 0;
    int done_cyc = 0;
    int last_out_cyc = 0;
    int job_hs_cyc = 0;
    bit out_ready_en = 1'b1;
    bit in_hs = 1'b0;
    bit hold_prev = 1'b0;
    logic [CHACHA_BLK_W-1:0] hold_data = '0;

    // Stand-in keystream for the core; any keyed function of (key, iv, counter) works here.
    function automatic logic [CHACHA_BLK_W-1:0] ks(
        input logic [CHACHA_KEY_W-1:0] key,
        input logic [CHACHA_IV_W-1:0]  iv,
        input logic [CHACHA_CTR_W-1:0] ctr
    );
        return {key, iv, ctr, ~key[127:0]};
    endfunction

    task automatic check(input string name, input logic [CHACHA_BLK_W-1:0] act,
                         input logic [CHACHA_BLK_W-1:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl_zero"},
              {job_ready, in_ready, out_valid, out_last, core_init, core_next, busy, done,
               ctr_wrap, blk_idx}, '0);
        check({tag, "_out_data_zero"}, out_data, '0);
        check({tag, "_core_bus_zero"}, {core_key, core_iv, core_ctr}, '0);
        check({tag, "_core_data_zero"}, core_data_in, '0);
    endtask

    // Behavioural core: init loads the counter, next advances it; result after CORE_LAT cycles.
    logic [CHACHA_CTR_W-1:0] m_ctr;
    logic [CHACHA_BLK_W-1:0] m_data;
    int                      m_cnt;
    always @(posedge clk) begin
        if (rst) begin
            core_ready          <= 1'b1;
            core_data_out_valid <= 1'b0;
            core_data_out       <= '0;
            m_cnt               <= 0;
        end else if (core_init || core_next) begin
            m_ctr               <= core_init ? core_ctr : m_ctr + 64'd1;
            m_data              <= core_data_in;
            core_ready          <= 1'b0;
            core_data_out_valid <= 1'b0;
            m_cnt               <= CORE_LAT;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                core_ready          <= 1'b1;
                core_data_out_valid <= 1'b1;
                core_data_out       <= m_data ^ ks(core_key, core_iv, m_ctr);
            end
        end
    end

    initial forever @(posedge clk) cyc++;

    // Input feeder: presents queued blocks; each accepted block pushes its expected result.
    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        forever @(negedge clk) begin
            if (in_hs && feed_q.size() > 0) begin
                feed_t f;
                f = feed_q.pop_front();
                exp_q.push_back('{data: f.data ^ ks(f.key, f.iv, f.ctr), last: f.last});
            end
            if (feed_q.size() > 0) begin
                in_valid = 1'b1;
                in_data  = feed_q[0].data;
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
            end
            #1;
            in_hs = in_valid && in_ready;
        end
    end

    // Output sink and scoreboard.
    initial begin
        out_ready = 1'b0;
        forever @(negedge clk) begin
            out_ready = out_ready_en;
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", out_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                end
                n_out++;
                last_out_cyc = cyc;
            end
        end
    end

    // Event monitor.
    initial forever @(negedge clk) begin
        #1;
        if (core_init) begin
            n_init++;
            init_cyc = cyc;
        end
        if (core_next) n_next++;
        if (core_init && core_next) n_both++;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (out_valid) n_outv++;
        if (hold_prev && out_valid && out_data !== hold_data) n_hold_viol++;
        hold_prev = out_valid && !out_ready;
        hold_data = out_data;
    end

    task automatic drive_job(input job_vec_t v, input string tag);
        int t;
        @(negedge clk);
        job_valid = 1'b1;
        job_key   = v.key;
        job_iv    = v.iv;
        job_ctr   = v.ctr;
        job_nblk  = NBLK_W'(v.nblk);
        #1;
        for (t = 0; t < TMO && !job_ready; t++) begin
            @(negedge clk);
            #1;
        end
        check({tag, "_job_accept"}, t < TMO, 1'b1);
        job_hs_cyc = cyc;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic push_blocks(input job_vec_t v);
        logic [CHACHA_BLK_W-1:0] blk;
        for (int b = 0; b < v.nblk; b++) begin
            for (int k = 0; k < 16; k++) blk[32*k +: 32] = $urandom();
            feed_q.push_back('{data: blk, key: v.key, iv: v.iv, ctr: v.ctr + 64'(b),
                               last: (b == v.nblk - 1)});
        end
    endtask

    task automatic run_job(input job_vec_t v, input string tag);
        int i0, x0, d0, o0, ov0, x1, t;
        i0 = n_init;
        x0 = n_next;
        d0 = n_done;
        o0 = n_out;
        ov0 = n_outv;
        out_ready_en = (v.stall == 0);
        push_blocks(v);
        drive_job(v, tag);
        #2;
        check({tag, "_wrap"}, ctr_wrap, v.exp_wrap);
        check({tag, "_idx_clear"}, blk_idx, '0);
        if (v.stall > 0) begin
            for (t = 0; t < TMO && !out_valid; t++) begin
                @(negedge clk);
                #2;
            end
            check({tag, "_first_out"}, t < TMO, 1'b1);
            x1 = n_next;
            repeat (v.stall) @(negedge clk);
            #2;
            check({tag, "_stall_no_next"}, n_next, x1);
            check({tag, "_stall_held"}, out_valid, 1'b1);
            out_ready_en = 1'b1;
        end
        for (t = 0; t < TMO && n_done == d0; t++) begin
            @(negedge clk);
            #2;
        end
        check({tag, "_done_seen"}, t < TMO, 1'b1);
        check({tag, "_init_cnt"}, n_init - i0, (v.nblk > 0) ? 1 : 0);
        check({tag, "_next_cnt"}, n_next - x0, (v.nblk > 0) ? v.nblk - 1 : 0);
        check({tag, "_out_cnt"}, n_out - o0, v.nblk);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
        check({tag, "_blk_idx"}, blk_idx, v.nblk);
        check({tag, "_ready_at_done"}, job_ready, 1'b0);
        if (v.nblk == 0) begin
            check({tag, "_done_lat"}, done_cyc - job_hs_cyc, 2);
            check({tag, "_no_outv"}, n_outv - ov0, 0);
        end else begin
            check({tag, "_init_lat"}, init_cyc - job_hs_cyc, 2);
            check({tag, "_done_after_out"}, done_cyc - last_out_cyc, 1);
        end
        @(negedge clk);
        #2;
        check({tag, "_ready_after_done"}, job_ready, 1'b1);
        check({tag, "_single_done"}, n_done - d0, 1);
    endtask

    initial begin
        job_vec_t vecs[6];
        job_vec_t v;
        int t, d0, x0;

        rst       = 1'b1;
        job_valid = 1'b0;
        job_key   = '0;
        job_iv    = '0;
        job_ctr   = '0;
        job_nblk  = '0;
        abort     = 1'b0;

        vecs[0] = '{key: {4{64'h0123456789abcdef}}, iv: 64'hdeadbeefcafebabe,
                    ctr: 64'd0, nblk: 3, stall: 0, exp_wrap: 1'b0};
        vecs[1] = '{key: {8{32'h13579bdf}}, iv: 64'h0011223344556677,
                    ctr: 64'h100, nblk: 3, stall: 20, exp_wrap: 1'b0};
        vecs[2] = '{key: {4{64'h0123456789abcdef}}, iv: 64'h1,
                    ctr: 64'd5, nblk: 0, stall: 0, exp_wrap: 1'b0};
        vecs[3] = '{key: {8{32'h13579bdf}}, iv: 64'h2,
                    ctr: 64'hFFFF_FFFF_FFFF_FFFE, nblk: 4, stall: 0, exp_wrap: 1'b1};
        vecs[4] = '{key: {4{64'h0123456789abcdef}}, iv: 64'h3,
                    ctr: 64'hFFFF_FFFF_FFFF_FFFC, nblk: 4, stall: 0, exp_wrap: 1'b0};
        vecs[5] = '{key: {8{32'h13579bdf}}, iv: 64'h4,
                    ctr: 64'hFFFF_FFFF_FFFF_FFFF, nblk: 1, stall: 0, exp_wrap: 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_job(vecs[i], $sformatf("job%0d", i));

        // Abort while block 2 of 4 is running in the core.
        v = '{key: {4{64'hfedcba9876543210}}, iv: 64'h55, ctr: 64'd10, nblk: 4, stall: 0,
              exp_wrap: 1'b0};
        out_ready_en = 1'b1;
        d0 = n_done;
        x0 = n_next;
        push_blocks(v);
        drive_job(v, "abort");
        #2;
        for (t = 0; t < TMO && n_next == x0; t++) begin
            @(negedge clk);
            #2;
        end
        check("abort_reach_blk2", t < TMO, 1'b1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #2;
        check("abort_busy", busy, 1'b0);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_out_last", out_last, 1'b0);
        check("abort_job_ready_low", job_ready, 1'b0);
        for (t = 0; t < TMO && !core_ready; t++) begin
            @(negedge clk);
            #2;
        end
        check("abort_core_idle", t < TMO, 1'b1);
        check("abort_job_ready_back", job_ready, 1'b1);
        repeat (5) @(negedge clk);
        #2;
        check("abort_no_done", n_done - d0, 0);
        feed_q.delete();
        exp_q.delete();

        // Reset while the first block is being issued.
        push_blocks(vecs[3]);
        drive_job(vecs[3], "rst_mid");
        #2;
        check("rst_mid_wrap_set", ctr_wrap, 1'b1);
        for (t = 0; t < TMO && !core_init; t++) begin
            @(negedge clk);
            #2;
        end
        check("rst_mid_reach_issue", t < TMO, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check_all_zero("rst_mid");
        rst = 1'b0;
        feed_q.delete();
        exp_q.delete();
        @(negedge clk);
        run_job(vecs[0], "post_rst");

        check("init_next_exclusive", n_both, 0);
        check("hold_stable", n_hold_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
